// File: rtl/vend_ctrl.sv
// Coin-operated drink vending controller: edge-detected coins, priority resolution,
// tick-timed vend/change/refund indication.
module vend_ctrl #(
   parameter int unsigned PRICE        = 10,
   parameter int unsigned VEND_TICKS   = 4,
   parameter int unsigned CHANGE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       r1,
   input  logic       r2,
   input  logic       r5,
   input  logic       cancel,
   output logic [4:0] credit,
   output logic [4:0] change,
   output logic       led_vend,
   output logic       led_change,
   output logic       busy,
   output logic       coin_rej
);

   localparam int unsigned CW = 5;
   localparam int unsigned TW = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      VEND    = 3'd2,
      CHANGE  = 3'd3,
      REFUND  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CW-1:0]   credit_d, change_d;
   logic            led_vend_d, led_change_d, coin_rej_d;
   logic            r1_q, r2_q, r5_q;
   logic            e1, e2, e5, any_edge, multi_edge;
   logic [CW-1:0]   coin_val, sum;

   // Rising-edge detection with r5 > r2 > r1 priority
   always_comb begin
      e1         = r1 & ~r1_q;
      e2         = r2 & ~r2_q;
      e5         = r5 & ~r5_q;
      any_edge   = e1 | e2 | e5;
      multi_edge = (e5 & (e2 | e1)) | (e2 & e1);
      if (e5)      coin_val = CW'(5);
      else if (e2) coin_val = CW'(2);
      else if (e1) coin_val = CW'(1);
      else         coin_val = '0;
      sum = credit + coin_val;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      credit_d   = credit;
      change_d   = change;
      timer_d    = tick ? timer_q + TW'(1) : timer_q;
      coin_rej_d = 1'b0;

      case (state_q)
         IDLE, COLLECT: begin
            if (any_edge) begin
               coin_rej_d = multi_edge;
               if (sum >= CW'(PRICE)) begin
                  credit_d = '0;
                  change_d = sum - CW'(PRICE);
                  state_d  = VEND;
               end else begin
                  credit_d = sum;
                  state_d  = COLLECT;
               end
            end else if (cancel && (state_q == COLLECT)) begin
               change_d = credit;
               credit_d = '0;
               state_d  = REFUND;
            end
         end
         VEND: begin
            coin_rej_d = any_edge;
            if (tick && (timer_q == TW'(VEND_TICKS - 1)))
               state_d = (change != '0) ? CHANGE : IDLE;
         end
         CHANGE, REFUND: begin
            coin_rej_d = any_edge;
            if (tick && (timer_q == TW'(CHANGE_TICKS - 1))) begin
               change_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) timer_d = '0;

      led_vend_d   = (state_d == VEND);
      led_change_d = (state_d == CHANGE) || (state_d == REFUND);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         credit     <= '0;
         change     <= '0;
         led_vend   <= 1'b0;
         led_change <= 1'b0;
         coin_rej   <= 1'b0;
         r1_q       <= 1'b0;
         r2_q       <= 1'b0;
         r5_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         credit     <= credit_d;
         change     <= change_d;
         led_vend   <= led_vend_d;
         led_change <= led_change_d;
         coin_rej   <= coin_rej_d;
         r1_q       <= r1;
         r2_q       <= r2;
         r5_q       <= r5;
      end
   end

   assign busy = (state_q == VEND) || (state_q == CHANGE) || (state_q == REFUND);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl at default parameters (PRICE=10, 4-tick holds).
module tb_vend_ctrl;

   logic       clk = 1'b0;
   logic       reset, tick, r1, r2, r5, cancel;
   logic [4:0] credit, change;
   logic       led_vend, led_change, busy, coin_rej;
   int         checks = 0;
   int         errors = 0;

   vend_ctrl dut (
      .clk(clk), .reset(reset), .tick(tick), .r1(r1), .r2(r2), .r5(r5),
      .cancel(cancel), .credit(credit), .change(change), .led_vend(led_vend),
      .led_change(led_change), .busy(busy), .coin_rej(coin_rej)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // {r5,r2,r1} pulse: one cycle high then one cycle low
   task automatic pulse_coin(input logic [2:0] m);
      {r5, r2, r1} = m;
      cyc();
      {r5, r2, r1} = 3'b000;
      cyc();
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_lv"}, led_vend, 0);
      chk({tag, "_lc"}, led_change, 0);
      chk({tag, "_chg"}, change, 0);
   endtask

   initial begin
      reset = 1'b0; tick = 1'b0; r1 = 1'b0; r2 = 1'b0; r5 = 1'b0; cancel = 1'b0;
      cyc();
      cyc();
      chk_idle("rst");
      chk("rst_credit", credit, 0);
      chk("rst_rej", coin_rej, 0);
      reset = 1'b1;
      cyc();

      // exact price: 5 + 5
      pulse_coin(3'b100);
      chk("t1_c5", credit, 5);
      chk("t1_busy0", busy, 0);
      pulse_coin(3'b100);
      chk("t1_c0", credit, 0);
      chk("t1_lv", led_vend, 1);
      chk("t1_chg", change, 0);
      do_ticks(3);
      chk("t1_lv3", led_vend, 1);
      do_ticks(1);
      chk_idle("t1_end");

      // 5 + 2 + 5 -> change 2
      pulse_coin(3'b100);
      chk("t2_c5", credit, 5);
      pulse_coin(3'b010);
      chk("t2_c7", credit, 7);
      pulse_coin(3'b100);
      chk("t2_c0", credit, 0);
      chk("t2_chg", change, 2);
      chk("t2_lv", led_vend, 1);
      chk("t2_lc0", led_change, 0);
      do_ticks(4);
      chk("t2_lv0", led_vend, 0);
      chk("t2_lc", led_change, 1);
      chk("t2_chg2", change, 2);
      do_ticks(3);
      chk("t2_lc3", led_change, 1);
      do_ticks(1);
      chk_idle("t2_end");

      // cancel in IDLE is ignored
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
      chk_idle("t3_cidle");

      // simultaneous edges: r5 wins, one reject pulse; holding adds nothing
      {r5, r2, r1} = 3'b111;
      cyc();
      chk("t4_c5", credit, 5);
      chk("t4_rej", coin_rej, 1);
      cyc();
      chk("t4_hold_c", credit, 5);
      chk("t4_hold_rej", coin_rej, 0);
      {r5, r2, r1} = 3'b000;
      cyc();
      chk("t4_c5b", credit, 5);
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
      chk("t4_ref_chg", change, 5);
      chk("t4_ref_c", credit, 0);
      do_ticks(4);
      chk_idle("t4_end");

      // credit 3 refund, coin during refund rejected
      pulse_coin(3'b010);
      pulse_coin(3'b001);
      chk("t5_c3", credit, 3);
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
      chk("t5_chg", change, 3);
      chk("t5_lc", led_change, 1);
      chk("t5_lv", led_vend, 0);
      chk("t5_busy", busy, 1);
      r2 = 1'b1;
      cyc();
      chk("t5_rej", coin_rej, 1);
      chk("t5_c0", credit, 0);
      r2 = 1'b0;
      cyc();
      chk("t5_rej0", coin_rej, 0);
      do_ticks(3);
      chk("t5_lc3", led_change, 1);
      do_ticks(1);
      chk_idle("t5_end");

      // credit 7, cancel + r2 together: coin wins
      pulse_coin(3'b100);
      pulse_coin(3'b010);
      chk("t6_c7", credit, 7);
      cancel = 1'b1;
      r2 = 1'b1;
      cyc();
      cancel = 1'b0;
      r2 = 1'b0;
      chk("t6_c9", credit, 9);
      chk("t6_busy", busy, 0);
      chk("t6_chg", change, 0);
      cyc();

      // 9 + 5 -> change 4, then reset mid-VEND discards it
      pulse_coin(3'b100);
      chk("t7_chg4", change, 4);
      chk("t7_lv", led_vend, 1);
      do_ticks(1);
      reset = 1'b0;
      #1;
      chk_idle("t7_rst");
      chk("t7_rst_c", credit, 0);
      r1 = 1'b1;
      cyc();
      reset = 1'b1;
      chk("t7_held_c0", credit, 0);
      cyc();
      chk("t7_r1_c1", credit, 1);
      chk_idle("t7_after");
      cyc();
      chk("t7_r1_once", credit, 1);
      r1 = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
